// File: rtl/flow_control_unit_p_if.sv
// Shared NoC packet/instruction types and the ip_port interface used by the
// flow-control unit to reach the memory-resident call stack.
package fcu_pkg;

    typedef struct packed {
        logic [127:0] inst;
        logic [63:0]  addr;
        logic [63:0]  len;
    } queued_instruction;

    typedef enum logic [2:0] {
        pkt_none,
        memory_write_request,
        memory_write_reply,
        memory_read_request,
        memory_read_reply
    } packet_type;

    typedef enum logic [1:0] {
        port_closed,
        port_open,
        port_busy
    } port_status;

    typedef struct packed {
        logic [7:0]   dst_addr;
        logic [3:0]   dst_prt;
        logic [7:0]   src_addr;
        logic [3:0]   src_prt;
        packet_type   pt;
        logic [3:0]   id;
        logic [127:0] dat;
    } noc_packet;

endpackage

// tx: core holds tx_submit with a stable dat_to_noc; the NoC accepts with a
// one-cycle tx_complete. rx: the NoC holds rx_recieve/dat_from_noc until it
// samples a one-cycle rx_complete from the core.
interface ip_port;
    import fcu_pkg::*;

    noc_packet   dat_to_noc;
    logic        tx_submit;
    logic        tx_complete;
    port_status  to_noc_prt_stat;
    logic        rx_recieve;
    noc_packet   dat_from_noc;
    logic        rx_complete;
    logic [7:0]  port_address;
    logic [3:0]  port_number;

    modport core (
        output dat_to_noc, tx_submit, rx_complete,
        input  tx_complete, to_noc_prt_stat, rx_recieve, dat_from_noc,
        input  port_address, port_number
    );

    modport noc (
        input  dat_to_noc, tx_submit, rx_complete,
        output tx_complete, to_noc_prt_stat, rx_recieve, dat_from_noc,
        output port_address, port_number
    );

endinterface

// File: rtl/flow_control_unit_p.sv
// Program-flow unit: JMP/JIZ/JCC resolve locally; GOT/RET push or pop the return
// address on a memory-resident stack over the NoC with timeout and retry.
module flow_control_unit_p
    import fcu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int FLAG_W      = 8,
    parameter int STACK_NODE  = 2,
    parameter int STACK_PORT  = 0,
    parameter int SLOT_BYTES  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  queued_instruction instruction,
    input  logic [FLAG_W-1:0] alu_status,
    output logic              done,
    output logic              busy,
    output logic              mdfy_pc,
    output logic [ADDR_W-1:0] new_pc_val,
    output logic              shp_we,
    output logic [ADDR_W-1:0] shp_inp,
    input  logic [ADDR_W-1:0] shp_oup,
    output logic              halt,
    output logic              fault,
    ip_port.core              noc_port
);

    localparam int IDX_W = $clog2(FLAG_W);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam int FLD   = 8 + ADDR_W;
    localparam logic [ADDR_W-1:0] SLOT = ADDR_W'(SLOT_BYTES);

    localparam logic [4:0] OP_JMP = 5'b00001;
    localparam logic [4:0] OP_JIZ = 5'b10001;
    localparam logic [4:0] OP_JCC = 5'b00101;
    localparam logic [4:0] OP_GOT = 5'b01001;
    localparam logic [4:0] OP_RET = 5'b11000;

    typedef enum logic [2:0] {S_IDLE, S_RESOLVE, S_SEND, S_WAIT, S_COMMIT} state_t;
    state_t state, state_d;

    logic [4:0]        op_q;
    logic [ADDR_W-1:0] tgt_q, here_q, ret_q, sp_q, rdat_q, rdat_d;
    logic [IDX_W-1:0]  idx_q;
    logic              pol_q;
    logic [FLAG_W-1:0] flags_q;
    logic [TMR_W-1:0]  timer, timer_d;
    logic [RTY_W-1:0]  retries, retries_d;
    logic [3:0]        tx_cnt, tx_cnt_d, cur_id, cur_id_d;
    logic              done_d, mdfy_d, shp_we_d, halt_d, fault_d, rxc_q, rxc_d;
    logic [ADDR_W-1:0] pc_d, shp_d;
    logic              idx_ok, taken, rx_new, reply_ok;
    noc_packet         pkt;
    logic              unused_bits;

    assign unused_bits = ^{instruction.inst, instruction.addr, instruction.len, noc_port.dat_from_noc};

    always_comb begin
        idx_ok = int'(idx_q) < FLAG_W;
        case (op_q)
            OP_JMP:  taken = 1'b1;
            OP_JIZ:  taken = flags_q[0];
            OP_JCC:  taken = idx_ok && (flags_q[idx_q] == pol_q);
            default: taken = 1'b0;
        endcase
    end

    // While rx_complete is high the NoC has not yet dropped the old reply, so ignore it.
    assign rx_new   = noc_port.rx_recieve && !rxc_q;
    assign reply_ok = rx_new && (noc_port.dat_from_noc.id == cur_id) &&
                      (noc_port.dat_from_noc.pt ==
                       ((op_q == OP_GOT) ? memory_write_reply : memory_read_reply));

    always_comb begin
        pkt          = '0;
        pkt.dst_addr = 8'(STACK_NODE);
        pkt.dst_prt  = 4'(STACK_PORT);
        pkt.src_addr = noc_port.port_address;
        pkt.src_prt  = noc_port.port_number;
        pkt.id       = tx_cnt;
        if (op_q == OP_GOT) begin
            pkt.pt                    = memory_write_request;
            pkt.dat[0 +: ADDR_W]      = sp_q - SLOT;
            pkt.dat[ADDR_W +: ADDR_W] = ret_q;
        end else begin
            pkt.pt               = memory_read_request;
            pkt.dat[0 +: ADDR_W] = sp_q;
        end
    end

    assign noc_port.dat_to_noc  = (state == S_SEND) ? pkt : '0;
    assign noc_port.tx_submit   = (state == S_SEND) && (noc_port.to_noc_prt_stat == port_open);
    assign noc_port.rx_complete = rxc_q;
    assign busy                 = (state != S_IDLE);

    always_comb begin
        state_d   = state;
        done_d    = 1'b0;
        mdfy_d    = 1'b0;
        shp_we_d  = 1'b0;
        fault_d   = 1'b0;
        rxc_d     = 1'b0;
        halt_d    = halt;
        pc_d      = new_pc_val;
        shp_d     = shp_inp;
        timer_d   = timer;
        retries_d = retries;
        tx_cnt_d  = tx_cnt;
        cur_id_d  = cur_id;
        rdat_d    = rdat_q;
        case (state)
            S_IDLE: begin
                retries_d = '0;
                if (en) begin
                    case (instruction.inst[7:3])
                        OP_JMP, OP_JIZ, OP_JCC: state_d = S_RESOLVE;
                        OP_GOT, OP_RET:         state_d = S_SEND;
                        default:                state_d = S_IDLE;
                    endcase
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (taken) begin
                    mdfy_d = 1'b1;
                    pc_d   = tgt_q;
                end
                if (op_q == OP_JMP && tgt_q == here_q) halt_d = 1'b1;
            end
            S_SEND: begin
                if (noc_port.tx_complete) begin
                    state_d  = S_WAIT;
                    timer_d  = '0;
                    cur_id_d = tx_cnt;
                    tx_cnt_d = tx_cnt + 4'd1;
                end
            end
            S_WAIT: begin
                if (reply_ok) begin
                    state_d = S_COMMIT;
                    rdat_d  = noc_port.dat_from_noc.dat[ADDR_W-1:0];
                end else begin
                    if (rx_new) rxc_d = 1'b1;
                    if (timer == TMR_W'(TIMEOUT_CYC)) begin
                        if (retries < RTY_W'(MAX_RETRY)) begin
                            state_d   = S_SEND;
                            retries_d = retries + 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            fault_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                mdfy_d   = 1'b1;
                shp_we_d = 1'b1;
                rxc_d    = 1'b1;
                if (op_q == OP_GOT) begin
                    pc_d  = tgt_q;
                    shp_d = sp_q - SLOT;
                end else begin
                    pc_d  = rdat_q;
                    shp_d = sp_q + SLOT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            mdfy_pc    <= 1'b0;
            new_pc_val <= '0;
            shp_we     <= 1'b0;
            shp_inp    <= '0;
            halt       <= 1'b0;
            fault      <= 1'b0;
            rxc_q      <= 1'b0;
            timer      <= '0;
            retries    <= '0;
            tx_cnt     <= '0;
            cur_id     <= '0;
            rdat_q     <= '0;
            op_q       <= '0;
            tgt_q      <= '0;
            here_q     <= '0;
            ret_q      <= '0;
            sp_q       <= '0;
            idx_q      <= '0;
            pol_q      <= 1'b0;
            flags_q    <= '0;
        end else begin
            state      <= state_d;
            done       <= done_d;
            mdfy_pc    <= mdfy_d;
            new_pc_val <= pc_d;
            shp_we     <= shp_we_d;
            shp_inp    <= shp_d;
            halt       <= halt_d;
            fault      <= fault_d;
            rxc_q      <= rxc_d;
            timer      <= timer_d;
            retries    <= retries_d;
            tx_cnt     <= tx_cnt_d;
            cur_id     <= cur_id_d;
            rdat_q     <= rdat_d;
            // Operands are captured every IDLE cycle so they freeze on the exit edge.
            if (state == S_IDLE) begin
                op_q    <= instruction.inst[7:3];
                tgt_q   <= instruction.inst[8 +: ADDR_W];
                idx_q   <= instruction.inst[FLD +: IDX_W];
                pol_q   <= instruction.inst[FLD + IDX_W];
                here_q  <= instruction.addr[ADDR_W-1:0];
                ret_q   <= instruction.addr[ADDR_W-1:0] + instruction.len[ADDR_W-1:0];
                sp_q    <= shp_oup;
                flags_q <= alu_status;
            end
        end
    end

endmodule

// File: tb/tb_flow_control_unit_p.sv
// Directed bench for flow_control_unit_p: jumps, call/return over a bench-driven
// NoC, wrong-id replies, timeout with retries, and reset during a transaction.
module tb_flow_control_unit_p;
    import fcu_pkg::*;

    localparam logic [4:0] OP_JMP = 5'b00001;
    localparam logic [4:0] OP_JIZ = 5'b10001;
    localparam logic [4:0] OP_JCC = 5'b00101;
    localparam logic [4:0] OP_GOT = 5'b01001;
    localparam logic [4:0] OP_RET = 5'b11000;

    logic              clk = 1'b0;
    logic              rst, en;
    queued_instruction instruction;
    logic [7:0]        alu_status;
    logic              done, busy, mdfy_pc, shp_we, halt, fault;
    logic [31:0]       new_pc_val, shp_inp, shp_oup;
    ip_port            noc();

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];
    noc_packet  p;
    logic       seen;

    flow_control_unit_p #(
        .ADDR_W(32), .FLAG_W(8), .STACK_NODE(2), .STACK_PORT(0),
        .SLOT_BYTES(4), .TIMEOUT_CYC(8), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .instruction(instruction),
        .alu_status(alu_status), .done(done), .busy(busy), .mdfy_pc(mdfy_pc),
        .new_pc_val(new_pc_val), .shp_we(shp_we), .shp_inp(shp_inp),
        .shp_oup(shp_oup), .halt(halt), .fault(fault), .noc_port(noc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_inst(input logic [4:0] op, input logic [31:0] tgt,
                                             input logic [2:0] idx, input logic pol);
        logic [127:0] v;
        v        = '0;
        v[7:3]   = op;
        v[8+:32] = tgt;
        v[40+:3] = idx;
        v[43]    = pol;
        return v;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] tgt, input logic [2:0] idx,
                         input logic pol, input logic [31:0] addr, input logic [31:0] len,
                         input logic [7:0] status);
        instruction.inst = mk_inst(op, tgt, idx, pol);
        instruction.addr = 64'(addr);
        instruction.len  = 64'(len);
        alu_status       = status;
        en               = 1'b1;
        tick();
        en               = 1'b0;
    endtask

    task automatic run_jump(input string tag, input logic [4:0] op, input logic [31:0] tgt,
                            input logic [2:0] idx, input logic pol, input logic [31:0] addr,
                            input logic [7:0] status, input logic exp_mdfy,
                            input logic [31:0] exp_pc);
        issue(op, tgt, idx, pol, addr, 32'h0, status);
        tick();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_mdfy"}, mdfy_pc, exp_mdfy);
        check({tag, "_pc"}, new_pc_val, exp_pc);
    endtask

    task automatic accept_tx(output noc_packet pk, output logic ok);
        ok = 1'b0;
        pk = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (noc.tx_submit) begin
                pk              = noc.dat_to_noc;
                ok              = 1'b1;
                noc.tx_complete = 1'b1;
                tick();
                noc.tx_complete = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    task automatic reply(input packet_type t, input logic [3:0] id, input logic [31:0] d);
        noc_packet q;
        q                = '0;
        q.pt             = t;
        q.id             = id;
        q.src_addr       = 8'd2;
        q.dat[31:0]      = d;
        noc.dat_from_noc = q;
        noc.rx_recieve   = 1'b1;
    endtask

    initial begin
        logic got_done, extra_tx, side, rxc_seen;
        rst                 = 1'b1;
        en                  = 1'b0;
        instruction         = '0;
        alu_status          = '0;
        shp_oup             = '0;
        noc.tx_complete     = 1'b0;
        noc.rx_recieve      = 1'b0;
        noc.dat_from_noc    = '0;
        noc.to_noc_prt_stat = port_open;
        noc.port_address    = 8'h05;
        noc.port_number     = 4'h1;
        tick();
        tick();
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pc", new_pc_val, 32'h0);
        check("rst_halt", halt, 1'b0);
        check("rst_txsub", noc.tx_submit, 1'b0);
        rst = 1'b0;
        tick();

        run_jump("jmp1", OP_JMP, 32'h100, 3'd0, 1'b0, 32'h40, 8'h00, 1'b1, 32'h100);
        check("jmp1_halt", halt, 1'b0);
        tick();
        check("jmp1_done_pulse", done, 1'b0);
        check("jmp1_pc_hold", new_pc_val, 32'h100);
        run_jump("jmp_self", OP_JMP, 32'h40, 3'd0, 1'b0, 32'h40, 8'h00, 1'b1, 32'h40);
        check("jmp_self_halt", halt, 1'b1);

        run_jump("jiz_nt", OP_JIZ, 32'h200, 3'd0, 1'b0, 32'h50, 8'h00, 1'b0, 32'h40);
        run_jump("jiz_t", OP_JIZ, 32'h200, 3'd0, 1'b0, 32'h50, 8'h01, 1'b1, 32'h200);
        run_jump("jcc3_nt", OP_JCC, 32'h180, 3'd3, 1'b0, 32'h60, 8'h08, 1'b0, 32'h200);
        run_jump("jcc3_t", OP_JCC, 32'h180, 3'd3, 1'b0, 32'h60, 8'h00, 1'b1, 32'h180);
        run_jump("jcc5_t", OP_JCC, 32'h1c0, 3'd5, 1'b1, 32'h60, 8'h20, 1'b1, 32'h1c0);
        run_jump("jcc5_nt", OP_JCC, 32'h1e0, 3'd5, 1'b1, 32'h60, 8'hDF, 1'b0, 32'h1c0);

        issue(5'b11111, 32'h500, 3'd0, 1'b0, 32'h70, 32'h0, 8'h00);
        check("unk_busy", busy, 1'b0);
        tick();
        check("unk_done", done, 1'b0);
        check("unk_pc", new_pc_val, 32'h1c0);
        check("halt_sticky", halt, 1'b1);

        // Call: push 0x20+6 at 0x1000-4, then jump to 0x300.
        shp_oup = 32'h1000;
        issue(OP_GOT, 32'h300, 3'd0, 1'b0, 32'h20, 32'h6, 8'h00);
        check("got_busy", busy, 1'b1);
        accept_tx(p, seen);
        check("got_tx_seen", seen, 1'b1);
        check("got_pt", p.pt, memory_write_request);
        check("got_addr", p.dat[31:0], 32'hFFC);
        check("got_data", p.dat[63:32], 32'h26);
        check("got_id", p.id, 4'd0);
        check("got_dst", {p.dst_addr, p.dst_prt}, {8'd2, 4'd0});
        check("got_src", {p.src_addr, p.src_prt}, {8'h05, 4'h1});
        check("got_txsub_low", noc.tx_submit, 1'b0);
        tick();
        reply(memory_write_reply, 4'd0, 32'h0);
        tick();
        check("got_rxc_early", noc.rx_complete, 1'b0);
        check("got_done_early", done, 1'b0);
        tick();
        check("got_rxc", noc.rx_complete, 1'b1);
        check("got_shp_we", shp_we, 1'b1);
        check("got_shp", shp_inp, 32'hFFC);
        check("got_mdfy", mdfy_pc, 1'b1);
        check("got_pc", new_pc_val, 32'h300);
        check("got_done", done, 1'b1);
        noc.rx_recieve = 1'b0;
        tick();
        check("got_rxc_pulse", noc.rx_complete, 1'b0);
        check("got_done_pulse", done, 1'b0);
        check("got_idle", busy, 1'b0);

        // Return, with a wrong-id reply that must be acked and dropped first.
        shp_oup = 32'hFFC;
        issue(OP_RET, 32'h0, 3'd0, 1'b0, 32'h300, 32'h0, 8'h00);
        accept_tx(p, seen);
        check("ret_tx_seen", seen, 1'b1);
        check("ret_pt", p.pt, memory_read_request);
        check("ret_addr", p.dat[31:0], 32'hFFC);
        check("ret_id", p.id, 4'd1);
        reply(memory_read_reply, 4'd7, 32'hBAD);
        tick();
        check("ret_bad_rxc", noc.rx_complete, 1'b1);
        check("ret_bad_busy", busy, 1'b1);
        tick();
        check("ret_bad_rxc_once", noc.rx_complete, 1'b0);
        check("ret_bad_done", done, 1'b0);
        check("ret_bad_still_wait", busy, 1'b1);
        noc.rx_recieve = 1'b0;
        tick();
        reply(memory_read_reply, 4'd1, 32'h26);
        tick();
        tick();
        check("ret_pc", new_pc_val, 32'h26);
        check("ret_shp", shp_inp, 32'h1000);
        check("ret_shp_we", shp_we, 1'b1);
        check("ret_done", done, 1'b1);
        noc.rx_recieve = 1'b0;
        tick();

        // No reply at all: three submissions, then done+fault with no state change.
        shp_oup = 32'h2000;
        issue(OP_RET, 32'h0, 3'd0, 1'b0, 32'h80, 32'h0, 8'h00);
        exp_q = {4'd2, 4'd3, 4'd4};
        for (int k = 0; k < 3; k++) begin
            accept_tx(p, seen);
            check($sformatf("to_sub%0d_seen", k), seen, 1'b1);
            check($sformatf("to_sub%0d_id", k), p.id, exp_q.pop_front());
        end
        got_done = 1'b0;
        extra_tx = 1'b0;
        side     = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (noc.tx_submit) extra_tx = 1'b1;
            if (shp_we || mdfy_pc) side = 1'b1;
            if (done) begin
                got_done = 1'b1;
                check("to_fault", fault, 1'b1);
            end else begin
                tick();
            end
        end
        check("to_done_seen", got_done, 1'b1);
        check("to_no_extra_tx", extra_tx, 1'b0);
        check("to_no_side", side, 1'b0);
        check("to_pc_kept", new_pc_val, 32'h26);
        check("to_shp_kept", shp_inp, 32'h1000);
        tick();
        check("to_fault_pulse", fault, 1'b0);
        check("to_idle", busy, 1'b0);

        // Reset while waiting; the late reply is ignored in IDLE, dropped in a later WAIT.
        shp_oup = 32'h1800;
        issue(OP_GOT, 32'h400, 3'd0, 1'b0, 32'h10, 32'h4, 8'h00);
        accept_tx(p, seen);
        check("rw_id", p.id, 4'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_busy", busy, 1'b0);
        check("rw_pc", new_pc_val, 32'h0);
        check("rw_shp", shp_inp, 32'h0);
        check("rw_halt", halt, 1'b0);
        check("rw_outs", {done, mdfy_pc, shp_we, fault, noc.tx_submit, noc.rx_complete}, 6'b0);
        reply(memory_write_reply, 4'd5, 32'h0);
        rxc_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (noc.rx_complete) rxc_seen = 1'b1;
        end
        check("late_idle_rxc", rxc_seen, 1'b0);
        shp_oup = 32'h3000;
        issue(OP_RET, 32'h0, 3'd0, 1'b0, 32'h90, 32'h0, 8'h00);
        accept_tx(p, seen);
        check("late_ret_id", p.id, 4'd0);
        check("late_ret_addr", p.dat[31:0], 32'h3000);
        check("late_rxc_early", noc.rx_complete, 1'b0);
        tick();
        check("late_wait_rxc", noc.rx_complete, 1'b1);
        check("late_wait_busy", busy, 1'b1);
        noc.rx_recieve = 1'b0;
        tick();
        check("late_rxc_once", noc.rx_complete, 1'b0);
        reply(memory_read_reply, 4'd0, 32'h55);
        tick();
        tick();
        check("late_ret_pc", new_pc_val, 32'h55);
        check("late_ret_shp", shp_inp, 32'h3004);
        check("late_ret_done", done, 1'b1);
        noc.rx_recieve = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
